audio_sample_recorder: RTL
==========================

# audio_sample_recorder

Capture engine that fills the 50-entry, 20-bit sample buffer later consumed by the fingerprint comparator. It accepts a streaming sample input with a valid strobe. Recording is armed by a switch level, starts on the first sample whose magnitude reaches a threshold, and keeps every DECIM-th valid sample. It presents the completed buffer as a flat array plus a done flag; the buffer holds its contents until the next recording starts.

## Interface
- N_SAMPLES, 50, buffer depth; fixed at 50 for the current comparator
- SAMPLE_W, 20, sample width, signed two's complement
- DECIM, 1, keep one of every DECIM valid samples; legal range 1..255
- THRESH, 1024, start-trigger magnitude; 0 means start on the first valid sample
- Clocking and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  system clock
- rst_n  in  1  async active-low reset
- record_SW  in  1  level arm/hold switch
- sample_valid  in  1  one-cycle strobe marking sample_data as a new sample
- sample_data  in  SAMPLE_W  incoming sample
- stored_sample  out  SAMPLE_W x N_SAMPLES  captured buffer, index 0 = trigger sample
- sample_count  out  6  number of samples written in the current or last recording
- busy  out  1  high in ARM or RECORD
- record_done  out  1  high in DONE

## Operation
- States:
  - IDLE: wait for a record_SW rising edge, detected against a registered copy of record_SW. On the edge, go to ARM, clear sample_count and clear the decimation counter. stored_sample is not cleared.
  - ARM: on sample_valid with |sample_data| >= THRESH, write that sample to index 0, set sample_count=1, set the decimation counter to 1 mod DECIM, and go to RECORD.
  - RECORD: on each sample_valid, if the decimation counter is 0, write to stored_sample[sample_count] and increment sample_count. The decimation counter advances on every valid sample and wraps at DECIM-1. When the write that makes sample_count = N_SAMPLES occurs, go to DONE.
  - DONE: hold. When record_SW is low, go to IDLE. record_done drops and the buffer is retained.
- Magnitude rule: |x| = -x for negative x. The value -2^19 saturates to 2^19-1. The comparison is unsigned on SAMPLE_W-1 bits.
- Abort: record_SW low in ARM or RECORD → IDLE on the next edge. The partial buffer and sample_count are kept. record_done is never asserted for an aborted run.
- sample_valid while in IDLE or DONE is ignored.
- The write index never exceeds N_SAMPLES-1. No write occurs in DONE.
- Simultaneous events: when record_SW falls in the same cycle as the 50th write, abort has priority. The write still lands, state goes to IDLE, and record_done stays 0.
- A record_SW rising edge seen in ARM, RECORD or DONE is ignored. Re-arming requires a low period that returns the block to IDLE.

## Timing
- Reset values: state IDLE, every stored_sample entry 0, sample_count 0, busy 0, record_done 0, record_SW history register 0.
- A rising edge of rst_n in a cycle where record_SW is already high counts as a rising edge.
- Latency:
  - record_SW rising edge → busy high 1 cycle after the edge is registered, i.e. 2 clocks after the switch goes high.
  - A sample accepted at edge k is visible on stored_sample and sample_count after edge k.
  - record_done rises on the same edge as the 50th write.
- Throughput: one sample per clock (sample_valid may be high continuously).
- Reset asserted mid-recording: immediate return to the reset values, including the buffer.

## Structure
- Shared package audio_fp_pkg: SAMPLE_W, N_SAMPLES, typedef sample_t (logic signed [SAMPLE_W-1:0]), typedef rec_state_t enum {IDLE, ARM, RECORD, DONE}.
- The comparator imports the same package.
- One sub-module, audio_trigger_detect: combinational saturating absolute value plus the >= THRESH compare, parameterised by SAMPLE_W and THRESH.
- The FSM, counters and buffer stay in the top module.

## Test plan
- Basic capture (THRESH=0, DECIM=1): switch high, then 50 consecutive valid samples 0..49 → stored_sample[i]=i, record_done high on the edge of sample 49, sample_count=50.
- Threshold (THRESH=1024): feed 10, -500, -1024, 7, ... → the trigger is -1024, stored_sample[0]=-1024, stored_sample[1]=7. The sample -2^19 also triggers, via saturation.
- Decimation (DECIM=4, THRESH=0): valid samples 0..199 → stored_sample[i]=4i, done after sample 196.
- Abort: record_SW low after 20 captures → state IDLE, sample_count=20, record_done never asserted. A fresh rising edge then a full run overwrites indices 0..49.
- Boundaries:
  - record_SW falls on the same edge as the 50th write → record_done stays 0 and index 49 is written.
  - rst_n pulsed mid-RECORD → all outputs and the buffer read 0 immediately.
  - valid samples in DONE leave the buffer unchanged.

Source files
------------

// File: rtl/audio_fp_pkg.sv
// ----------------------------------------------------------------------------
// audio_fp_pkg
// Types and constants shared by the audio sample recorder and the fingerprint
// comparator that consumes its buffer.
//   SAMPLE_W    : width of one signed sample
//   N_SAMPLES   : depth of the capture buffer
//   COUNT_W     : width of the sample counter (holds 0..N_SAMPLES)
//   DEC_W       : width of the decimation counter (DECIM up to 255)
//   sample_t    : one signed sample
//   sample_buf_t: the whole buffer as a flat packed array, index 0 first
//   rec_state_t : recorder FSM states
// ----------------------------------------------------------------------------
package audio_fp_pkg;

    localparam int SAMPLE_W  = 20;
    localparam int N_SAMPLES = 50;
    localparam int COUNT_W   = 6;
    localparam int DEC_W     = 8;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic [N_SAMPLES-1:0][SAMPLE_W-1:0] sample_buf_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        RECORD = 2'd2,
        DONE   = 2'd3
    } rec_state_t;

endpackage

// File: rtl/audio_sample_recorder_if.sv
// ----------------------------------------------------------------------------
// audio_sample_recorder_if
// Bundles the recorder's control, sample stream and buffer outputs.
//   record_SW     : arm/hold switch level (master -> slave)
//   sample_valid  : one-cycle strobe qualifying sample_data (master -> slave)
//   sample_data   : incoming signed sample (master -> slave)
//   stored_sample : captured buffer, index 0 = trigger sample (slave -> master)
//   sample_count  : samples written in current/last recording (slave -> master)
//   busy          : recorder armed or recording (slave -> master)
//   record_done   : buffer complete (slave -> master)
// The recorder connects through the slave modport; the sample source and
// buffer consumer use the master modport.
// ----------------------------------------------------------------------------
interface audio_sample_recorder_if;
    import audio_fp_pkg::*;

    logic               record_SW;
    logic               sample_valid;
    sample_t            sample_data;
    sample_buf_t        stored_sample;
    logic [COUNT_W-1:0] sample_count;
    logic               busy;
    logic               record_done;

    modport master (
        output record_SW,
        output sample_valid,
        output sample_data,
        input  stored_sample,
        input  sample_count,
        input  busy,
        input  record_done
    );

    modport slave (
        input  record_SW,
        input  sample_valid,
        input  sample_data,
        output stored_sample,
        output sample_count,
        output busy,
        output record_done
    );

endinterface

// File: rtl/audio_trigger_detect.sv
// ----------------------------------------------------------------------------
// audio_trigger_detect
// Combinational start-trigger check: saturating magnitude of a signed sample
// compared against THRESH.
//   sample_i : signed sample under test
//   hit_o    : 1 when |sample_i| >= THRESH
// The most negative value has no positive counterpart, so its magnitude
// saturates to the largest positive value (all ones on SAMPLE_W-1 bits).
// ----------------------------------------------------------------------------
module audio_trigger_detect #(
    parameter int SAMPLE_W = 20,
    parameter int THRESH   = 1024
) (
    input  logic signed [SAMPLE_W-1:0] sample_i,
    output logic                       hit_o
);

    localparam logic [SAMPLE_W:0] THRESH_V = (SAMPLE_W+1)'(THRESH);

    logic [SAMPLE_W-1:0] raw;
    logic [SAMPLE_W-1:0] neg;
    logic [SAMPLE_W-2:0] mag;

    assign raw = sample_i;
    assign neg = -raw;

    always_comb begin
        mag = raw[SAMPLE_W-2:0];
        if (raw[SAMPLE_W-1]) begin
            // Negating the most negative value leaves the sign bit set.
            if (neg[SAMPLE_W-1]) begin
                mag = '1;
            end else begin
                mag = neg[SAMPLE_W-2:0];
            end
        end
    end

    // Zero-extended so the compare is unsigned on the magnitude bits.
    assign hit_o = {2'b00, mag} >= THRESH_V;

endmodule

// File: rtl/audio_sample_recorder.sv
// ----------------------------------------------------------------------------
// audio_sample_recorder
// Switch-armed capture engine: once armed, waits for a sample whose magnitude
// reaches THRESH, then keeps every DECIM-th valid sample until N_SAMPLES are
// stored. The buffer is held until the next recording overwrites it.
//   clk   : system clock
//   rst_n : asynchronous active-low reset (clears the buffer as well)
//   bus   : audio_sample_recorder_if.slave (switch, sample stream, buffer,
//           sample_count, busy, record_done)
// Parameters: DECIM (1..255) decimation factor, THRESH start magnitude
// (0 starts on the first valid sample).
// ----------------------------------------------------------------------------
module audio_sample_recorder
    import audio_fp_pkg::*;
#(
    parameter int DECIM  = 1,
    parameter int THRESH = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    audio_sample_recorder_if.slave  bus
);

    localparam logic [DEC_W-1:0]   DEC_LAST  = DEC_W'(DECIM - 1);
    // Phase of the sample after the trigger: 1 mod DECIM.
    localparam logic [DEC_W-1:0]   DEC_START = (DECIM == 1) ? '0 : DEC_W'(1);
    localparam logic [COUNT_W-1:0] LAST_IDX  = COUNT_W'(N_SAMPLES - 1);

    rec_state_t         state_q;
    logic               sw_hist_q;
    logic               rise_q;
    logic [COUNT_W-1:0] count_q;
    logic [DEC_W-1:0]   dec_q;
    logic               busy_q;
    logic               done_q;
    sample_t            buf_q [N_SAMPLES];

    logic trig_hit;
    logic keep_d;
    logic last_write_d;

    audio_trigger_detect #(
        .SAMPLE_W (SAMPLE_W),
        .THRESH   (THRESH)
    ) u_trigger (
        .sample_i (bus.sample_data),
        .hit_o    (trig_hit)
    );

    assign keep_d       = (dec_q == '0);
    assign last_write_d = (count_q == LAST_IDX);

    // A switch edge is registered into rise_q first, so busy rises two
    // clocks after the switch goes high. Abort uses the live switch level,
    // and its assignments come last so they override a completing write's
    // state change while the write itself still lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sw_hist_q <= 1'b0;
            rise_q    <= 1'b0;
            count_q   <= '0;
            dec_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            for (int i = 0; i < N_SAMPLES; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            sw_hist_q <= bus.record_SW;
            rise_q    <= bus.record_SW & ~sw_hist_q;

            case (state_q)
                IDLE: begin
                    if (rise_q) begin
                        state_q <= ARM;
                        busy_q  <= 1'b1;
                        count_q <= '0;
                        dec_q   <= '0;
                    end
                end

                ARM: begin
                    if (bus.sample_valid && trig_hit) begin
                        buf_q[0] <= bus.sample_data;
                        count_q  <= COUNT_W'(1);
                        dec_q    <= DEC_START;
                        state_q  <= RECORD;
                    end
                    if (!bus.record_SW) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                RECORD: begin
                    if (bus.sample_valid) begin
                        if (keep_d && (count_q <= LAST_IDX)) begin
                            buf_q[count_q] <= bus.sample_data;
                            count_q        <= count_q + COUNT_W'(1);
                            if (last_write_d) begin
                                state_q <= DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end
                        dec_q <= (dec_q == DEC_LAST) ? '0 : dec_q + DEC_W'(1);
                    end
                    if (!bus.record_SW) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                end

                DONE: begin
                    if (!bus.record_SW) begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sample_count = count_q;
    assign bus.busy         = busy_q;
    assign bus.record_done  = done_q;

    generate
        for (genvar gi = 0; gi < N_SAMPLES; gi++) begin : g_out
            assign bus.stored_sample[gi] = buf_q[gi];
        end
    endgenerate

endmodule
